// File: rtl/lockin_pkg.sv
// Shared lock-in amplifier constants.
// Used by the NCO, mixer and filter stages so that all word widths agree.
//   LOCKIN_DATA_W : signed ADC sample width
//   LOCKIN_SIN_W  : signed sine/cosine reference width
//   LOCKIN_PROD_W : full-precision mixer product width
package lockin_pkg;

    localparam int unsigned LOCKIN_DATA_W = 24;
    localparam int unsigned LOCKIN_SIN_W  = 18;
    localparam int unsigned LOCKIN_PROD_W = LOCKIN_DATA_W + LOCKIN_SIN_W;

endpackage : lockin_pkg

// File: rtl/signed_mult.sv
// Combinational full-precision signed multiplier, intended to map onto a DSP block.
// Ports:
//   a : signed operand, A_WIDTH bits
//   b : signed operand, B_WIDTH bits
//   p : signed product a*b, A_WIDTH+B_WIDTH bits (never overflows)
module signed_mult #(
    parameter int unsigned A_WIDTH = 24,
    parameter int unsigned B_WIDTH = 18
) (
    input  logic signed [A_WIDTH-1:0]         a,
    input  logic signed [B_WIDTH-1:0]         b,
    output logic signed [A_WIDTH+B_WIDTH-1:0] p
);

    // Both operands and the result are signed, so the operands are sign-extended
    // to the full product width before the multiply.
    assign p = a * b;

endmodule : signed_mult

// File: rtl/mixer.sv
// Lock-in demodulation mixer: multiplies one signed sample by the reference sine
// and cosine, registering the in-phase and quadrature products.
// Ports:
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset
//   start          : operands valid this cycle
//   data_in        : signed input sample
//   sine_in        : signed reference sine
//   cosine_in      : signed reference cosine
//   phase_out      : registered data_in*sine_in
//   quadrature_out : registered data_in*cosine_in
//   o_valid        : high for the cycle after an accepted start
module mixer
    import lockin_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LOCKIN_DATA_W,
    parameter int unsigned SIN_WIDTH  = LOCKIN_SIN_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic signed [DATA_WIDTH-1:0]          data_in,
    input  logic signed [SIN_WIDTH-1:0]           sine_in,
    input  logic signed [SIN_WIDTH-1:0]           cosine_in,
    output logic signed [DATA_WIDTH+SIN_WIDTH-1:0] phase_out,
    output logic signed [DATA_WIDTH+SIN_WIDTH-1:0] quadrature_out,
    output logic                                  o_valid
);

    localparam int unsigned PROD_WIDTH = DATA_WIDTH + SIN_WIDTH;

    logic signed [PROD_WIDTH-1:0] phase_prod;
    logic signed [PROD_WIDTH-1:0] quad_prod;

    signed_mult #(
        .A_WIDTH (DATA_WIDTH),
        .B_WIDTH (SIN_WIDTH)
    ) u_mult_sin (
        .a (data_in),
        .b (sine_in),
        .p (phase_prod)
    );

    signed_mult #(
        .A_WIDTH (DATA_WIDTH),
        .B_WIDTH (SIN_WIDTH)
    ) u_mult_cos (
        .a (data_in),
        .b (cosine_in),
        .p (quad_prod)
    );

    // Products load only on start; otherwise they hold for the downstream filter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_out      <= '0;
            quadrature_out <= '0;
            o_valid        <= 1'b0;
        end else begin
            o_valid <= start;
            if (start) begin
                phase_out      <= phase_prod;
                quadrature_out <= quad_prod;
            end
        end
    end

endmodule : mixer

// File: tb/tb_mixer.sv
module tb_mixer;

    localparam int DW = 24;
    localparam int SW = 18;
    localparam int PW = DW + SW;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic signed [DW-1:0] data_in;
    logic signed [SW-1:0] sine_in;
    logic signed [SW-1:0] cosine_in;
    logic signed [PW-1:0] phase_out;
    logic signed [PW-1:0] quadrature_out;
    logic                 o_valid;

    int checks   = 0;
    int failures = 0;

    mixer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .data_in        (data_in),
        .sine_in        (sine_in),
        .cosine_in      (cosine_in),
        .phase_out      (phase_out),
        .quadrature_out (quadrature_out),
        .o_valid        (o_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; data_in = '0; sine_in = '0; cosine_in = '0;
        for (int i = 0; i < 3; i++) begin
            // third cycle: start asserted with live operands while reset is low
            if (i == 2) begin
                start = 1'b1; data_in = 24'sd1234; sine_in = 18'sd99; cosine_in = -18'sd7;
            end
            tick();
            checks++;
            if (phase_out !== PW'(0)) begin
                failures++;
                $display("FAIL reset_phase cyc=%0d got=%0d exp=0", i, phase_out);
            end
            checks++;
            if (quadrature_out !== PW'(0)) begin
                failures++;
                $display("FAIL reset_quad cyc=%0d got=%0d exp=0", i, quadrature_out);
            end
            checks++;
            if (o_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, o_valid);
            end
        end
        start = 1'b0;
        #3 reset = 1'b1;
        tick();
    endtask

    // Single start pulse, then operands scrambled with start low: outputs must hold.
    task automatic test_single(input string name, input int d, input int s, input int c,
                               input longint exp_p, input longint exp_q);
        data_in = DW'(d); sine_in = SW'(s); cosine_in = SW'(c); start = 1'b1;
        tick();
        start = 1'b0; data_in = 24'sd333; sine_in = 18'sd55; cosine_in = -18'sd44;
        checks++;
        if (phase_out !== PW'(exp_p)) begin
            failures++;
            $display("FAIL %s_phase got=%0d exp=%0d", name, phase_out, exp_p);
        end
        checks++;
        if (quadrature_out !== PW'(exp_q)) begin
            failures++;
            $display("FAIL %s_quad got=%0d exp=%0d", name, quadrature_out, exp_q);
        end
        checks++;
        if (o_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid got=%b exp=1", name, o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_valid_drop got=%b exp=0", name, o_valid);
        end
        checks++;
        if (phase_out !== PW'(exp_p) || quadrature_out !== PW'(exp_q)) begin
            failures++;
            $display("FAIL %s_hold got=%0d/%0d exp=%0d/%0d", name, phase_out,
                     quadrature_out, exp_p, exp_q);
        end
    endtask

    task automatic test_back_to_back();
        sine_in = 18'sd7; cosine_in = 18'sd7;
        for (int i = 1; i <= 3; i++) begin
            data_in = DW'(i); start = 1'b1;
            tick();
            checks++;
            if (phase_out !== PW'(7 * i) || quadrature_out !== PW'(7 * i)) begin
                failures++;
                $display("FAIL b2b_prod i=%0d got=%0d/%0d exp=%0d", i, phase_out,
                         quadrature_out, 7 * i);
            end
            checks++;
            if (o_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_valid i=%0d got=%b exp=1", i, o_valid);
            end
        end
        start = 1'b0; data_in = 24'sd9;
        tick();
        checks++;
        if (o_valid !== 1'b0 || phase_out !== PW'(21)) begin
            failures++;
            $display("FAIL b2b_end got valid=%b phase=%0d exp valid=0 phase=21", o_valid,
                     phase_out);
        end
    endtask

    task automatic test_reset_mid();
        data_in = 24'sd5; sine_in = 18'sd3; cosine_in = -18'sd2; start = 1'b1;
        tick();
        checks++;
        if (phase_out !== PW'(15) || quadrature_out !== PW'(-10) || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got=%0d/%0d/%b exp=15/-10/1", phase_out, quadrature_out,
                     o_valid);
        end
        // new operation in flight, then reset between edges
        data_in = 24'sd100; sine_in = 18'sd100;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (phase_out !== PW'(0) || quadrature_out !== PW'(0) || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_async got=%0d/%0d/%b exp=0/0/0", phase_out, quadrature_out,
                     o_valid);
        end
        tick();
        checks++;
        if (phase_out !== PW'(0) || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_held got=%0d/%b exp=0/0", phase_out, o_valid);
        end
        start = 1'b0;
        #3 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (phase_out !== PW'(0) || quadrature_out !== PW'(0) || o_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_release cyc=%0d got=%0d/%0d/%b exp=0/0/0", i, phase_out,
                         quadrature_out, o_valid);
            end
        end
        data_in = 24'sd2; sine_in = 18'sd3; cosine_in = 18'sd4; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (phase_out !== PW'(6) || quadrature_out !== PW'(8) || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_restart got=%0d/%0d/%b exp=6/8/1", phase_out, quadrature_out,
                     o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single("pos", 1000, 500, 250, 64'sd500000, 64'sd250000);
        test_single("neg", -1000, 500, 250, -64'sd500000, -64'sd250000);
        test_single("ext", -8388608, -131072, 131071, 64'sd1099511627776,
                    -64'sd1099503239168);
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mixer
